// File: rtl/updown_counter_n.sv
// updown_counter_n
//   Parametrised synchronous up/down counter with a configurable modulus.
//   It supports count enable, synchronous clear and load, and two overflow
//   modes: wrap modulo (MAX_VALUE+1), or saturate at the bounds.
//   Its status outputs feed downstream timers, dividers and cascaded counter
//   chains.
//
// Parameters
//   WIDTH        counter width in bits (2..32)
//   MAX_VALUE    highest count; the modulus is MAX_VALUE+1 (1..2**WIDTH-1)
//   RESET_VALUE  count after reset (<= MAX_VALUE)
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   enable      in   step the count by one this cycle
//   up_down     in   1 = increment, 0 = decrement
//   clear       in   synchronous clear to 0 (highest priority)
//   load        in   synchronous load of load_value (clamped to MAX_VALUE)
//   load_value  in   [WIDTH] value to load
//   saturate    in   1 = saturate at the bounds, 0 = wrap
//   count       out  [WIDTH] registered count
//   at_max      out  count == MAX_VALUE (combinational)
//   at_min      out  count == 0 (combinational)
//   wrap_pulse  out  registered; high for the one cycle after a wrapping edge
//   sat_flag    out  registered, sticky; set when saturation blocked a step
//
// Cascading: drive the next stage's enable with (enable & at_max) when
// counting up, or with (enable & at_min) when counting down.
module updown_counter_n #(
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  MAX_VALUE   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             saturate,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_pulse,
    output logic             sat_flag
);

    // Bound compares are done one bit wider than the count. This keeps the
    // load clamp and the limit tests free of overflow, even when MAX_VALUE
    // is all ones.
    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_VALUE};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   load_ext;
    logic             below_max;
    logic             above_min;
    logic             load_over;

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    assign cnt_ext   = {1'b0, count};
    assign load_ext  = {1'b0, load_value};
    assign below_max = (cnt_ext < MAX_EXT);
    assign above_min = (cnt_ext != '0);
    assign load_over = (load_ext > MAX_EXT);

    assign at_max = (cnt_ext == MAX_EXT);
    assign at_min = !above_min;

    // Next-state selection. The priority is clear > load > enable. The
    // increment and decrement are applied only when the bound test shows
    // that the step stays within 0..MAX_VALUE. Because of that, the WIDTH-bit
    // arithmetic below can never overflow.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        sat_nxt   = sat_flag;
        if (clear) begin
            count_nxt = '0;
            sat_nxt   = 1'b0;
        end else if (load) begin
            count_nxt = load_over ? MAX_VALUE : load_value;
            sat_nxt   = 1'b0;
        end else if (enable) begin
            if (up_down) begin
                if (below_max) begin
                    count_nxt = count + ONE;
                end else if (saturate) begin
                    sat_nxt   = 1'b1;
                end else begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (above_min) begin
                    count_nxt = count - ONE;
                end else if (saturate) begin
                    sat_nxt   = 1'b1;
                end else begin
                    count_nxt = MAX_VALUE;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count      <= RESET_VALUE;
            wrap_pulse <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            count      <= count_nxt;
            wrap_pulse <= wrap_nxt;
            sat_flag   <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n. It runs two instances side by side:
//   dut_a  WIDTH=4, MAX_VALUE=9  (decade counter; wrap, saturate, load clamp,
//                                 clear priority, mid-count reset)
//   dut_b  WIDTH=8 defaults      (gated up/down sweep 0..128..0)
// A modulo-arithmetic reference model tracks each instance. A negedge
// process compares every output against the model, and the directed
// sequence adds hand-computed literal expectations.
module tb_updown_counter_n;

    localparam int A_MAX = 9;
    localparam int B_MAX = 255;

    typedef struct packed {
        int c;
        bit w;
        bit s;
    } mstate_t;

    logic clock = 1'b0;
    logic reset;

    logic       a_en, a_ud, a_clr, a_ld, a_sat;
    logic [3:0] a_lv;
    logic [3:0] a_cnt;
    logic       a_amax, a_amin, a_wrap, a_sflag;

    logic       b_en, b_ud, b_clr, b_ld, b_sat;
    logic [7:0] b_lv;
    logic [7:0] b_cnt;
    logic       b_amax, b_amin, b_wrap, b_sflag;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    mstate_t ma, mb;

    always #5 clock = ~clock;

    updown_counter_n #(.WIDTH(4), .MAX_VALUE(4'd9), .RESET_VALUE(4'd0)) dut_a (
        .clock(clock), .reset(reset), .enable(a_en), .up_down(a_ud),
        .clear(a_clr), .load(a_ld), .load_value(a_lv), .saturate(a_sat),
        .count(a_cnt), .at_max(a_amax), .at_min(a_amin),
        .wrap_pulse(a_wrap), .sat_flag(a_sflag)
    );

    updown_counter_n #(.WIDTH(8)) dut_b (
        .clock(clock), .reset(reset), .enable(b_en), .up_down(b_ud),
        .clear(b_clr), .load(b_ld), .load_value(b_lv), .saturate(b_sat),
        .count(b_cnt), .at_max(b_amax), .at_min(b_amin),
        .wrap_pulse(b_wrap), .sat_flag(b_sflag)
    );

    // Reference model: one edge of counter behaviour in plain modulo arithmetic.
    function automatic mstate_t model_next(mstate_t cur, int maxv, bit clr, bit ld,
                                           bit en, bit ud, bit sat, int lv);
        mstate_t n;
        n   = cur;
        n.w = 1'b0;
        if (clr) begin
            n.c = 0;
            n.s = 1'b0;
        end else if (ld) begin
            n.c = (lv > maxv) ? maxv : lv;
            n.s = 1'b0;
        end else if (en) begin
            if (ud) begin
                if (cur.c == maxv && sat) n.s = 1'b1;
                else begin
                    n.w = (cur.c == maxv);
                    n.c = (cur.c + 1) % (maxv + 1);
                end
            end else begin
                if (cur.c == 0 && sat) n.s = 1'b1;
                else begin
                    n.w = (cur.c == 0);
                    n.c = (cur.c + maxv) % (maxv + 1);
                end
            end
        end
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= model_next(ma, A_MAX, a_clr, a_ld, a_en, a_ud, a_sat, int'(a_lv));
            mb <= model_next(mb, B_MAX, b_clr, b_ld, b_en, b_ud, b_sat, int'(b_lv));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Compare every output against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_on) begin
            check("a_count",  32'(a_cnt),   32'(ma.c));
            check("a_at_max", 32'(a_amax),  32'(ma.c == A_MAX));
            check("a_at_min", 32'(a_amin),  32'(ma.c == 0));
            check("a_wrap",   32'(a_wrap),  32'(ma.w));
            check("a_sat",    32'(a_sflag), 32'(ma.s));
            check("b_count",  32'(b_cnt),   32'(mb.c));
            check("b_at_max", 32'(b_amax),  32'(mb.c == B_MAX));
            check("b_at_min", 32'(b_amin),  32'(mb.c == 0));
            check("b_wrap",   32'(b_wrap),  32'(mb.w));
            check("b_sat",    32'(b_sflag), 32'(mb.s));
        end
    end

    // Advance n clock edges and land 1 ns after the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int  exp_up[12];
        bit  wrap_seen;
        exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        reset = 1'b1;
        {a_en, a_ud, a_clr, a_ld, a_sat} = '0; a_lv = '0;
        {b_en, b_ud, b_clr, b_ld, b_sat} = '0; b_lv = '0;
        #1 reset = 1'b0;
        #2;
        check("rst_a_count", 32'(a_cnt),   32'd0);
        check("rst_a_wrap",  32'(a_wrap),  32'd0);
        check("rst_a_sat",   32'(a_sflag), 32'd0);
        check("rst_a_min",   32'(a_amin),  32'd1);
        check("rst_b_count", 32'(b_cnt),   32'd0);
        #9 reset = 1'b1;          // t=12, released between edges
        chk_on = 1'b1;
        cyc(1);

        // Count up through the wrap from 9 to 0.
        a_en = 1'b1; a_ud = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            check("up_seq_count", 32'(a_cnt),  32'(exp_up[i]));
            check("up_seq_wrap",  32'(a_wrap), 32'(i == 9));
        end

        // Clear, then count down from 0, which wraps to 9.
        a_en = 1'b0; a_clr = 1'b1;
        cyc(1);
        check("clear_count", 32'(a_cnt), 32'd0);
        a_clr = 1'b0; a_en = 1'b1; a_ud = 1'b0;
        cyc(1);
        check("down_wrap_count", 32'(a_cnt),  32'd9);
        check("down_wrap_pulse", 32'(a_wrap), 32'd1);
        check("down_wrap_max",   32'(a_amax), 32'd1);
        a_en = 1'b0;
        cyc(1);
        check("wrap_one_cycle", 32'(a_wrap), 32'd0);

        // Saturate at the upper bound; a later load clears the sticky flag.
        a_sat = 1'b1; a_ld = 1'b1; a_lv = 4'd9;
        cyc(1);
        a_ld = 1'b0; a_en = 1'b1; a_ud = 1'b1;
        cyc(1);
        check("sat_hold_count", 32'(a_cnt),   32'd9);
        check("sat_flag_set",   32'(a_sflag), 32'd1);
        cyc(2);
        check("sat_hold_count2", 32'(a_cnt),  32'd9);
        check("sat_no_wrap",     32'(a_wrap), 32'd0);
        a_en = 1'b0; a_ld = 1'b1; a_lv = 4'd3;
        cyc(1);
        check("load3_count", 32'(a_cnt),   32'd3);
        check("load3_sat",   32'(a_sflag), 32'd0);

        // A load above MAX_VALUE is clamped; clear wins over load and enable.
        a_lv = 4'd15;
        cyc(1);
        check("load_clamp", 32'(a_cnt), 32'd9);
        a_clr = 1'b1; a_en = 1'b1;
        cyc(1);
        check("clear_prio", 32'(a_cnt), 32'd0);

        // Saturate at the lower bound; the flag stays set while idle.
        a_clr = 1'b0; a_ld = 1'b0; a_ud = 1'b0;
        cyc(1);
        check("sat_min_count", 32'(a_cnt),   32'd0);
        check("sat_min_flag",  32'(a_sflag), 32'd1);
        a_en = 1'b0;
        cyc(1);
        check("sat_sticky", 32'(a_sflag), 32'd1);

        // Assert reset in the middle of a count.
        a_sat = 1'b0; a_ud = 1'b1; a_en = 1'b1;
        cyc(6);
        check("pre_reset_count", 32'(a_cnt), 32'd6);
        #3 reset = 1'b0;
        #1;
        check("async_reset_count", 32'(a_cnt),   32'd0);
        check("async_reset_sat",   32'(a_sflag), 32'd0);
        cyc(1);
        check("reset_hold_count", 32'(a_cnt), 32'd0);
        reset = 1'b1;
        cyc(1);
        check("resume_count", 32'(a_cnt), 32'd1);
        a_en = 1'b0;

        // 8-bit sweep with enable on every other cycle: 0 up to 128, then back down to 0.
        wrap_seen = 1'b0;
        b_ud = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b_en = (i % 2 == 0);
            cyc(1);
            wrap_seen |= b_wrap;
        end
        check("b_peak_count", 32'(b_cnt), 32'd128);
        b_ud = 1'b0;
        for (int i = 0; i < 256; i++) begin
            b_en = (i % 2 == 0);
            cyc(1);
            wrap_seen |= b_wrap;
        end
        b_en = 1'b0;
        check("b_end_count",  32'(b_cnt),     32'd0);
        check("b_end_at_min", 32'(b_amin),    32'd1);
        check("b_no_wrap",    32'(wrap_seen), 32'd0);

        cyc(2);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
